// File: rtl/si_nave_position_ctrl.sv
// ---------------------------------------------------------------------------
// si_nave_position_ctrl
//
// Player-ship position controller for the Space Invaders datapath.
// Holds the ship column as a one-hot register and steps it toward bit 0
// (LEFT) or toward bit WIDTH-1 (RIGHT) at a rate of one step every MOVE_DIV
// frame ticks while a single direction is held. A hit freezes the ship for
// FREEZE_TICKS frame ticks, after which it respawns at START_POS.
//
// Optional feature macro:
//   SI_NAVE_CTRL_WRAP_EN  - when defined, stepping past either edge wraps
//                           around to the opposite edge and the edge
//                           indicators are constantly 2'b11.
//
// Parameters:
//   WIDTH         number of columns (>= 2)
//   MOVE_DIV      frame ticks per step while a direction is held (>= 1)
//   START_POS     column loaded at reset and at respawn (0..WIDTH-1)
//   FREEZE_TICKS  frame ticks the ship stays frozen after a hit (>= 1)
//
// Ports:
//   SI_NAVE_CTRL_CLOCK_50     in   system clock
//   SI_NAVE_CTRL_RESET_InLow  in   asynchronous active-low reset
//   SI_NAVE_CTRL_TICK_IN      in   one-cycle frame-tick strobe
//   SI_NAVE_CTRL_LEFT_IN      in   level, request a step toward bit 0
//   SI_NAVE_CTRL_RIGHT_IN     in   level, request a step toward bit WIDTH-1
//   SI_NAVE_CTRL_HIT_IN       in   one-cycle pulse, ship was hit
//   SI_NAVE_CTRL_POS_OUT      out  one-hot ship column [WIDTH-1:0]
//   SI_NAVE_CTRL_IND_BUS      out  [1] step toward MSB allowed,
//                                  [0] step toward LSB allowed
//   SI_NAVE_CTRL_STEP_OUT     out  one-cycle pulse aligned with a new POS
//   SI_NAVE_CTRL_FROZEN_OUT   out  high while the ship is frozen
// ---------------------------------------------------------------------------
module si_nave_position_ctrl #(
    parameter int WIDTH        = 8,
    parameter int MOVE_DIV     = 4,
    parameter int START_POS    = 3,
    parameter int FREEZE_TICKS = 8
) (
    input  logic             SI_NAVE_CTRL_CLOCK_50,
    input  logic             SI_NAVE_CTRL_RESET_InLow,
    input  logic             SI_NAVE_CTRL_TICK_IN,
    input  logic             SI_NAVE_CTRL_LEFT_IN,
    input  logic             SI_NAVE_CTRL_RIGHT_IN,
    input  logic             SI_NAVE_CTRL_HIT_IN,
    output logic [WIDTH-1:0] SI_NAVE_CTRL_POS_OUT,
    output logic [1:0]       SI_NAVE_CTRL_IND_BUS,
    output logic             SI_NAVE_CTRL_STEP_OUT,
    output logic             SI_NAVE_CTRL_FROZEN_OUT
);

    // Counter widths never drop below one bit so the degenerate
    // MOVE_DIV = 1 / FREEZE_TICKS = 1 cases still elaborate.
    localparam int MV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int FZ_W = (FREEZE_TICKS > 1) ? $clog2(FREEZE_TICKS) : 1;

    localparam logic [MV_W-1:0]  MV_LAST      = MV_W'(MOVE_DIV - 1);
    localparam logic [FZ_W-1:0]  FZ_LAST      = FZ_W'(FREEZE_TICKS - 1);
    localparam logic [WIDTH-1:0] START_ONEHOT = WIDTH'(1) << START_POS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FROZEN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic             dir_right_q, dir_right_d;
    logic [MV_W-1:0]  mv_cnt_q, mv_cnt_d;
    logic [FZ_W-1:0]  fz_cnt_q, fz_cnt_d;
    logic             step_q, step_d;

    logic             req_l;
    logic             req_r;
    logic             req_any;
    logic             allow_l;
    logic             allow_r;
    logic             step_allowed;
    logic [WIDTH-1:0] pos_rot_l;
    logic [WIDTH-1:0] pos_rot_r;

    // Both buttons or neither button means "no request".
    assign req_l   = SI_NAVE_CTRL_LEFT_IN & ~SI_NAVE_CTRL_RIGHT_IN;
    assign req_r   = SI_NAVE_CTRL_RIGHT_IN & ~SI_NAVE_CTRL_LEFT_IN;
    assign req_any = req_l | req_r;

    // Rotations keep the register one-hot by construction. Without wrap
    // they are only applied when the ship is away from the edge, where a
    // rotate and a plain shift give the same result.
    assign pos_rot_l = {pos_q[0], pos_q[WIDTH-1:1]};
    assign pos_rot_r = {pos_q[WIDTH-2:0], pos_q[WIDTH-1]};

`ifdef SI_NAVE_CTRL_WRAP_EN
    assign allow_l = 1'b1;
    assign allow_r = 1'b1;
`else
    assign allow_l = ~pos_q[0];
    assign allow_r = ~pos_q[WIDTH-1];
`endif

    assign step_allowed = dir_right_q ? allow_r : allow_l;

    // State register and all datapath registers; reset restores the
    // spawn column with every counter cleared.
    always_ff @(posedge SI_NAVE_CTRL_CLOCK_50 or negedge SI_NAVE_CTRL_RESET_InLow) begin
        if (!SI_NAVE_CTRL_RESET_InLow) begin
            state_q     <= ST_IDLE;
            pos_q       <= START_ONEHOT;
            dir_right_q <= 1'b0;
            mv_cnt_q    <= '0;
            fz_cnt_q    <= '0;
            step_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            dir_right_q <= dir_right_d;
            mv_cnt_q    <= mv_cnt_d;
            fz_cnt_q    <= fz_cnt_d;
            step_q      <= step_d;
        end
    end

    // Next-state logic. A hit takes priority over everything in IDLE and
    // RUN, so a hit arriving with a step tick suppresses that step. In
    // FROZEN the buttons and further hits are ignored; only ticks advance
    // the freeze counter until the respawn.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        dir_right_d = dir_right_q;
        mv_cnt_d    = mv_cnt_q;
        fz_cnt_d    = fz_cnt_q;
        step_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mv_cnt_d = '0;
                if (SI_NAVE_CTRL_HIT_IN) begin
                    state_d  = ST_FROZEN;
                    fz_cnt_d = '0;
                end else if (req_any) begin
                    // A tick in this same cycle is deliberately not counted.
                    state_d     = ST_RUN;
                    dir_right_d = req_r;
                end
            end

            ST_RUN: begin
                if (SI_NAVE_CTRL_HIT_IN) begin
                    state_d  = ST_FROZEN;
                    fz_cnt_d = '0;
                    mv_cnt_d = '0;
                end else if (!req_any) begin
                    state_d  = ST_IDLE;
                    mv_cnt_d = '0;
                end else if (req_r != dir_right_q) begin
                    // Reversal restarts the rate divider so the very next
                    // tick moves the ship in the new direction.
                    dir_right_d = req_r;
                    mv_cnt_d    = '0;
                end else if (SI_NAVE_CTRL_TICK_IN) begin
                    if ((mv_cnt_q == '0) && step_allowed) begin
                        pos_d  = dir_right_q ? pos_rot_r : pos_rot_l;
                        step_d = 1'b1;
                    end
                    // The divider advances even when the step is blocked.
                    if (mv_cnt_q == MV_LAST) begin
                        mv_cnt_d = '0;
                    end else begin
                        mv_cnt_d = mv_cnt_q + MV_W'(1);
                    end
                end
            end

            ST_FROZEN: begin
                if (SI_NAVE_CTRL_TICK_IN) begin
                    if (fz_cnt_q == FZ_LAST) begin
                        state_d  = ST_IDLE;
                        pos_d    = START_ONEHOT;
                        fz_cnt_d = '0;
                        mv_cnt_d = '0;
                    end else begin
                        fz_cnt_d = fz_cnt_q + FZ_W'(1);
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                pos_d    = START_ONEHOT;
                mv_cnt_d = '0;
                fz_cnt_d = '0;
            end
        endcase
    end

    // Edge indicators come straight from the position register.
`ifdef SI_NAVE_CTRL_WRAP_EN
    assign SI_NAVE_CTRL_IND_BUS = 2'b11;
`else
    assign SI_NAVE_CTRL_IND_BUS = {~pos_q[WIDTH-1], ~pos_q[0]};
`endif

    assign SI_NAVE_CTRL_POS_OUT    = pos_q;
    assign SI_NAVE_CTRL_STEP_OUT   = step_q;
    assign SI_NAVE_CTRL_FROZEN_OUT = (state_q == ST_FROZEN);

endmodule

// File: doc/si_nave_position_ctrl.md
# si_nave_position_ctrl

Parametrised player-ship position controller for the Space Invaders datapath. It holds the ship column as a one-hot register of WIDTH columns and steps it left or right from the player buttons, at a rate derived from the frame tick. It reports edge indicators to the rest of the game and freezes the ship after a hit, then respawns it. It sits between the button debouncers and the ship renderer / collision logic. It replaces the fixed 8-column combinational edge comparator with a registered, rate-limited controller.

## Interface
Parameters:
- WIDTH, 8: number of columns; must be ≥ 2.
- MOVE_DIV, 4: frame ticks per step while a direction is held; must be ≥ 1.
- START_POS, 3: column index loaded at reset and at respawn; 0 ≤ START_POS < WIDTH.
- FREEZE_TICKS, 8: frame ticks the ship stays frozen after a hit; must be ≥ 1.

Ports:
- SI_NAVE_CTRL_CLOCK_50  in  1  system clock; the only clock.
- SI_NAVE_CTRL_RESET_InLow  in  1  reset, asynchronous, active-low.
- SI_NAVE_CTRL_TICK_IN  in  1  one-cycle frame-tick strobe.
- SI_NAVE_CTRL_LEFT_IN  in  1  level; request a step toward bit 0.
- SI_NAVE_CTRL_RIGHT_IN  in  1  level; request a step toward bit WIDTH-1.
- SI_NAVE_CTRL_HIT_IN  in  1  one-cycle pulse; the ship was hit.
- SI_NAVE_CTRL_POS_OUT  out  WIDTH  one-hot ship column.
- SI_NAVE_CTRL_IND_BUS  out  2  edge indicators:
  - bit 1 = a step toward the MSB is allowed.
  - bit 0 = a step toward the LSB is allowed.
  - Values: 2'b10 at bit 0, 2'b01 at bit WIDTH-1, 2'b11 elsewhere.
- SI_NAVE_CTRL_STEP_OUT  out  1  one-cycle pulse, high in the cycle a step takes effect.
- SI_NAVE_CTRL_FROZEN_OUT  out  1  high while in FROZEN.

## Operation
- Request:
  - req_l = LEFT & !RIGHT; req_r = RIGHT & !LEFT.
  - Both high or both low means no request.
- States:
  - IDLE:
    - No request: stay in IDLE with tick counter = 0.
    - Request present: go to RUN with counter = 0 and the direction latched.
  - RUN:
    - On each tick_in, if the counter is 0 and the step is allowed, shift POS one place in the latched direction and pulse STEP_OUT.
    - On every tick_in, counter = (counter+1) mod MOVE_DIV.
    - Request drops: go to IDLE.
    - Request reverses direction: counter clears to 0 and the new direction is latched, so the next tick steps immediately.
  - FROZEN:
    - Entered from any state on HIT_IN.
    - Button inputs are ignored.
    - A freeze counter increments on each tick_in.
    - On the FREEZE_TICKS-th tick, POS reloads one-hot START_POS and the state goes to IDLE.
- Step blocked at an edge: POS does not change, no STEP_OUT pulse, and the counter still advances.
- IND_BUS is decoded combinationally from the POS register.
- HIT_IN and a step tick in the same cycle: HIT_IN wins and no step occurs.
- HIT_IN while already in FROZEN is ignored; it does not retrigger the freeze counter.
- POS is always exactly one-hot.

## Timing
- Reset values:
  - POS_OUT = 1<<START_POS.
  - IND_BUS = decode of that value (2'b11 for the defaults).
  - STEP_OUT = 0, FROZEN_OUT = 0.
  - State IDLE, all counters 0.
- Asserting reset mid-operation (any state) returns every register to these values immediately.
- Step latency: POS updates on the clock edge that samples the qualifying tick_in. STEP_OUT is high for exactly the following cycle, aligned with the new POS.
- The request-to-RUN transition takes one clock. A tick coincident with the first request cycle is not counted.
- FROZEN_OUT rises the cycle after HIT_IN is sampled. It falls the same cycle that POS shows START_POS.
- Counter widths: $clog2(MOVE_DIV) and $clog2(FREEZE_TICKS), minimum 1 bit each.

## Configuration
- SI_NAVE_CTRL_WRAP_EN defined:
  - A step past bit 0 wraps to bit WIDTH-1, and past WIDTH-1 wraps to bit 0, with a STEP_OUT pulse.
  - IND_BUS is constantly 2'b11.
- Undefined: edges block steps as described in Operation.

## Test plan
All scenarios use default parameters; tick_in pulses every 10 clocks.
- Reset: hold reset low, then release. Expect POS=8'b00001000, IND=2'b11, STEP=0, FROZEN=0.
- Move left to the edge: hold LEFT for 13 ticks.
  - Steps occur on ticks 1, 5, 9: POS=00000100, then 00000010, then 00000001.
  - IND becomes 2'b10; tick 13 gives no step and no STEP_OUT.
- Move right across the full width: start at bit 0 and hold RIGHT.
  - 7 steps spaced 4 ticks apart reach POS=10000000, IND=2'b01.
- Conflicting buttons and reversal:
  - LEFT and RIGHT both high for 10 ticks: POS unchanged.
  - Switch from LEFT to RIGHT mid-count: the next tick steps right.
- Hit and respawn: pulse HIT_IN while in RUN, coincident with a step tick.
  - No step occurs; FROZEN=1 and buttons are ignored for 8 ticks.
  - A second HIT_IN during the freeze changes nothing.
  - Then POS=00001000 and FROZEN=0.
- With SI_NAVE_CTRL_WRAP_EN: at POS=00000001 with LEFT held, the next step gives POS=10000000 and STEP=1; IND stays 2'b11.
